// File: rtl/pwm_gate_guard_pkg.sv
// Shared types and constants for the pwm_gate_guard gate-drive protection block.
package pwm_gate_guard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_SHOOT = 2'b01;
    localparam logic [1:0] FC_WDOG  = 2'b10;

endpackage

// File: rtl/pwm_dt_timer.sv
// Saturating deadtime counter: counts cycles with both gates off, dt_ok once MIN_DT is reached.
module pwm_dt_timer #(
    parameter int MIN_DT = 20,
    parameter int CNT_W  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic gates_off,
    output logic dt_ok
);

    localparam logic [CNT_W-1:0] DT_MAX = CNT_W'(MIN_DT);

    if ((longint'(1) << CNT_W) <= longint'(MIN_DT)) begin : g_cnt_w_check
        $error("CNT_W is too narrow to hold MIN_DT");
    end

    logic [CNT_W-1:0] dt_cnt_q;
    logic [CNT_W-1:0] dt_cnt_d;

    // NOTE: next-state logic assigns its default first, so no path can infer a latch.
    always_comb begin
        dt_cnt_d = dt_cnt_q;
        if (!gates_off) begin
            dt_cnt_d = '0;
        end else if (dt_cnt_q != DT_MAX) begin
            dt_cnt_d = dt_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dt_cnt_q <= '0;
        end else begin
            dt_cnt_q <= dt_cnt_d;
        end
    end

    assign dt_ok = (dt_cnt_q == DT_MAX);

endmodule

// File: rtl/pwm_gate_guard.sv
// Gate-drive guard behind the PWM/deadtime stage: enforces MIN_DT, latches shoot-through faults.
// Optional input-activity watchdog is enabled by defining PWM_GATE_GUARD_WDOG_EN.
module pwm_gate_guard
    import pwm_gate_guard_pkg::*;
#(
    parameter int MIN_DT      = 20,
    parameter int CNT_W       = 8,
    parameter int WDOG_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_hi_in,
    input  logic       pwm_lo_in,
    input  logic       fault_clr,
    output logic       gate_hi,
    output logic       gate_lo,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic       dt_stretch
);

    if (WDOG_CYCLES < 1) begin : g_wdog_check
        $error("WDOG_CYCLES must be at least 1");
    end

    state_e     state_q, state_d;
    logic       gate_hi_q, gate_hi_d;
    logic       gate_lo_q, gate_lo_d;
    logic       fault_q, fault_d;
    logic [1:0] fault_code_q, fault_code_d;
    logic       dt_stretch_q, dt_stretch_d;
    logic [1:0] pend_q, pend_d;
    logic       gates_off;
    logic       dt_ok;
    logic       wdog_hit;

    assign gates_off = ~(gate_hi_q | gate_lo_q);

    pwm_dt_timer #(
        .MIN_DT(MIN_DT),
        .CNT_W (CNT_W)
    ) u_dt_timer (
        .clk      (clk),
        .rst      (rst),
        .gates_off(gates_off),
        .dt_ok    (dt_ok)
    );

`ifdef PWM_GATE_GUARD_WDOG_EN
    localparam int              WD_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_CYCLES);

    logic [WD_W-1:0] wdog_q;
    logic            hi_dly_q, lo_dly_q;
    logic            in_edge;

    assign in_edge = (pwm_hi_in ^ hi_dly_q) | (pwm_lo_in ^ lo_dly_q);

    // Any input toggle restarts the timeout; the count only runs while gating normally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q   <= '0;
            hi_dly_q <= 1'b0;
            lo_dly_q <= 1'b0;
        end else begin
            hi_dly_q <= pwm_hi_in;
            lo_dly_q <= pwm_lo_in;
            if (state_q != RUN || in_edge) begin
                wdog_q <= '0;
            end else if (wdog_q != WD_MAX) begin
                wdog_q <= wdog_q + 1'b1;
            end
        end
    end

    assign wdog_hit = (state_q == RUN) && (wdog_q == WD_MAX);
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        gate_hi_d    = gate_hi_q;
        gate_lo_d    = gate_lo_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        pend_d       = 2'b00;
        dt_stretch_d = 1'b0;
        case (state_q)
            RUN: begin
                if (pwm_hi_in && pwm_lo_in) begin
                    state_d      = FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FC_SHOOT;
                    gate_hi_d    = 1'b0;
                    gate_lo_d    = 1'b0;
                end else if (wdog_hit) begin
                    state_d      = FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FC_WDOG;
                    gate_hi_d    = 1'b0;
                    gate_lo_d    = 1'b0;
                end else begin
                    // Turn-on waits for deadtime and the opposite gate; turn-off is immediate.
                    gate_hi_d    = gate_hi_q ? pwm_hi_in : (pwm_hi_in && dt_ok && !gate_lo_q);
                    gate_lo_d    = gate_lo_q ? pwm_lo_in : (pwm_lo_in && dt_ok && !gate_hi_q);
                    pend_d       = {pwm_lo_in && !gate_lo_q && !dt_ok,
                                    pwm_hi_in && !gate_hi_q && !dt_ok};
                    dt_stretch_d = |(pend_d & ~pend_q);
                end
            end
            FAULT: begin
                gate_hi_d = 1'b0;
                gate_lo_d = 1'b0;
                if (fault_clr && !pwm_hi_in && !pwm_lo_in) begin
                    state_d      = RUN;
                    fault_d      = 1'b0;
                    fault_code_d = FC_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            gate_hi_q    <= 1'b0;
            gate_lo_q    <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            dt_stretch_q <= 1'b0;
            pend_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            gate_hi_q    <= gate_hi_d;
            gate_lo_q    <= gate_lo_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            dt_stretch_q <= dt_stretch_d;
            pend_q       <= pend_d;
        end
    end

    assign gate_hi    = gate_hi_q;
    assign gate_lo    = gate_lo_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign dt_stretch = dt_stretch_q;

endmodule

// File: tb/tb_pwm_gate_guard.sv
// Self-checking bench for pwm_gate_guard: directed scenarios plus randomized traffic vs a timestamp model.
// Watchdog expectations follow PWM_GATE_GUARD_WDOG_EN, matching the DUT build.
module tb_pwm_gate_guard;

    localparam int MIN_DT      = 20;
    localparam int CNT_W       = 8;
    localparam int WDOG_CYCLES = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_hi_in = 1'b0;
    logic       pwm_lo_in = 1'b0;
    logic       fault_clr = 1'b0;
    logic       gate_hi;
    logic       gate_lo;
    logic       fault;
    logic [1:0] fault_code;
    logic       dt_stretch;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Reference model: deadtime judged from the edge index at which both gates were last seen off.
    logic       m_run = 1'b1;
    logic       m_hi = 1'b0, m_lo = 1'b0, m_fault = 1'b0, m_stretch = 1'b0;
    logic [1:0] m_code = 2'b00;
    logic       m_wait_hi = 1'b0, m_wait_lo = 1'b0;
    int         m_off_since = 0;

    pwm_gate_guard #(
        .MIN_DT     (MIN_DT),
        .CNT_W      (CNT_W),
        .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_hi_in (pwm_hi_in),
        .pwm_lo_in (pwm_lo_in),
        .fault_clr (fault_clr),
        .gate_hi   (gate_hi),
        .gate_lo   (gate_lo),
        .fault     (fault),
        .fault_code(fault_code),
        .dt_stretch(dt_stretch)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: time limit reached before summary");
        $fatal(1, "bench time limit");
    end

    function automatic void model_step(input logic h, input logic l, input logic c, input logic r);
        logic ok, wh, wl;
        if (r) begin
            m_run = 1'b1; m_hi = 1'b0; m_lo = 1'b0; m_fault = 1'b0; m_code = 2'b00;
            m_stretch = 1'b0; m_wait_hi = 1'b0; m_wait_lo = 1'b0; m_off_since = edge_n;
            return;
        end
        ok = ((edge_n - 1 - m_off_since) >= MIN_DT);
        if (m_hi || m_lo) m_off_since = edge_n;
        m_stretch = 1'b0;
        if (m_run) begin
            if (h && l) begin
                m_run = 1'b0; m_fault = 1'b1; m_code = 2'b01;
                m_hi = 1'b0; m_lo = 1'b0; m_wait_hi = 1'b0; m_wait_lo = 1'b0;
            end else begin
                wh = h && !m_hi && !ok;
                wl = l && !m_lo && !ok;
                m_stretch = (wh && !m_wait_hi) || (wl && !m_wait_lo);
                m_wait_hi = wh;
                m_wait_lo = wl;
                if (m_hi) m_hi = h; else m_hi = h && ok && !m_lo;
                if (m_lo) m_lo = l; else m_lo = l && ok && !m_hi;
            end
        end else begin
            m_hi = 1'b0; m_lo = 1'b0; m_wait_hi = 1'b0; m_wait_lo = 1'b0;
            if (c && !h && !l) begin
                m_run = 1'b1; m_fault = 1'b0; m_code = 2'b00;
            end
        end
    endfunction

    task automatic cyc(input logic h, input logic l, input logic c, input logic r);
        pwm_hi_in = h;
        pwm_lo_in = l;
        fault_clr = c;
        rst       = r;
        @(posedge clk);
        edge_n++;
        model_step(h, l, c, r);
        #1;
    endtask

    task automatic test_reset();
        repeat (100) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({gate_hi, gate_lo, fault, fault_code, dt_stretch} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_state: got %b, expected 000000", {gate_hi, gate_lo, fault, fault_code, dt_stretch});
        end
    endtask

    task automatic test_reset_release();
        int rise = 0;
        int pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (dt_stretch) pulses++;
            if (gate_hi && rise == 0) rise = k;
        end
        n_tests++;
        if (rise != MIN_DT + 1) begin
            n_fail++;
            $display("FAIL release_latency: gate_hi rose after %0d cycles, expected %0d", rise, MIN_DT + 1);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL release_stretch: %0d pulses, expected 1", pulses);
        end
    endtask

    task automatic test_gap(input int gap);
        int rise = 0;
        int pulses = 0;
        int exp_rise;
        exp_rise = (gap >= MIN_DT + 1) ? 1 : MIN_DT + 2 - gap;
        repeat (200) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (gate_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL gap%0d_setup: gate_hi=%b, expected 1", gap, gate_hi);
        end
        repeat (gap) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (dt_stretch) pulses++;
        end
        for (int k = 1; k <= 200; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (dt_stretch) pulses++;
            if (gate_lo && rise == 0) rise = k;
        end
        n_tests++;
        if (rise != exp_rise) begin
            n_fail++;
            $display("FAIL gap%0d_latency: gate_lo rose at cycle %0d, expected %0d", gap, rise, exp_rise);
        end
        n_tests++;
        if (pulses != ((exp_rise > 1) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL gap%0d_stretch: %0d pulses, expected %0d", gap, pulses, (exp_rise > 1) ? 1 : 0);
        end
    endtask

    task automatic test_short_pulse();
        int lo_on = 0;
        int pulses = 0;
        repeat (40) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (gate_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL short_setup: gate_hi=%b, expected 1", gate_hi);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 35; k++) begin
            cyc(1'b0, (k < 5) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (gate_lo) lo_on++;
            if (dt_stretch) pulses++;
        end
        n_tests++;
        if (lo_on != 0) begin
            n_fail++;
            $display("FAIL short_gate_lo: gate_lo high %0d cycles, expected 0", lo_on);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL short_stretch: %0d pulses, expected 1", pulses);
        end
    endtask

    task automatic test_shoot_through();
        int k = 0;
        int bad = 0;
        while (!gate_hi && k < 60) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            k++;
        end
        n_tests++;
        if (gate_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL shoot_setup: gate_hi=%b after %0d cycles, expected 1", gate_hi, k);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({gate_hi, gate_lo, fault, fault_code} !== 5'b00101) begin
            n_fail++;
            $display("FAIL shoot_fault: hi/lo/fault/code=%b, expected 00101", {gate_hi, gate_lo, fault, fault_code});
        end
        for (int i = 0; i < 20; i++) begin
            cyc((i < 10) ? 1'b1 : 1'b0, (i < 10) ? 1'b0 : 1'b1, 1'b0, 1'b0);
            if (gate_hi || gate_lo || !fault) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL shoot_hold: %0d cycles with a gate on or fault dropped, expected 0", bad);
        end
    endtask

    task automatic test_clear();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if ({fault, fault_code} !== 3'b101) begin
            n_fail++;
            $display("FAIL clear_blocked_hi: fault/code=%b, expected 101", {fault, fault_code});
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_blocked_lo: fault=%b, expected 1", fault);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if ({gate_hi, gate_lo, fault, fault_code} !== 5'b00000) begin
            n_fail++;
            $display("FAIL clear_ok: hi/lo/fault/code=%b, expected 00000", {gate_hi, gate_lo, fault, fault_code});
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({gate_hi, dt_stretch} !== 2'b10) begin
            n_fail++;
            $display("FAIL clear_dt_carry: gate_hi/stretch=%b, expected 10", {gate_hi, dt_stretch});
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({gate_hi, gate_lo, fault, fault_code} !== 5'b00101) begin
            n_fail++;
            $display("FAIL fault_beats_clear: hi/lo/fault/code=%b, expected 00101", {gate_hi, gate_lo, fault, fault_code});
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if ({gate_hi, gate_lo, fault, fault_code, dt_stretch} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_in_fault: got %b, expected 000000", {gate_hi, gate_lo, fault, fault_code, dt_stretch});
        end
        repeat (MIN_DT + 1) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if ({gate_hi, fault} !== 2'b10) begin
            n_fail++;
            $display("FAIL run_after_reset: gate_hi/fault=%b, expected 10", {gate_hi, fault});
        end
    endtask

    task automatic test_watchdog();
        int hit = 0;
        logic [1:0] hit_code = 2'b00;
        logic hit_gate = 1'b0;
        repeat (30) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= WDOG_CYCLES + 200; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (fault && hit == 0) begin
                hit = k;
                hit_code = fault_code;
                hit_gate = gate_hi;
            end
        end
`ifdef PWM_GATE_GUARD_WDOG_EN
        n_tests++;
        if (hit < WDOG_CYCLES - 5 || hit > WDOG_CYCLES + 5) begin
            n_fail++;
            $display("FAIL wdog_timing: fault at cycle %0d, expected about %0d", hit, WDOG_CYCLES);
        end
        n_tests++;
        if ({hit_code, hit_gate} !== 3'b100) begin
            n_fail++;
            $display("FAIL wdog_code: code/gate_hi=%b, expected 100", {hit_code, hit_gate});
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if ({fault, fault_code} !== 3'b000) begin
            n_fail++;
            $display("FAIL wdog_clear: fault/code=%b, expected 000", {fault, fault_code});
        end
`else
        n_tests++;
        if (hit != 0 || gate_hi !== 1'b1) begin
            n_fail++;
            $display("FAIL no_wdog: fault at cycle %0d gate_hi=%b, expected no fault and gate_hi=1", hit, gate_hi);
        end
`endif
    endtask

    task automatic test_random();
        int kind, len;
        logic h, l, c;
        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 150; p++) begin
            kind = int'($urandom_range(0, 9));
            len  = (kind == 8) ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 60));
            h    = (kind < 4) || (kind == 8);
            l    = (kind >= 4) && (kind <= 8);
            for (int k = 0; k < len; k++) begin
                c = (kind == 9) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
                cyc(h, l, c, 1'b0);
                n_tests++;
                if ({gate_hi, gate_lo, fault, fault_code, dt_stretch} !==
                    {m_hi, m_lo, m_fault, m_code, m_stretch}) begin
                    n_fail++;
                    $display("FAIL random_edge%0d: hi/lo/fault/code/stretch=%b, expected %b", edge_n,
                             {gate_hi, gate_lo, fault, fault_code, dt_stretch},
                             {m_hi, m_lo, m_fault, m_code, m_stretch});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_gap(30);
        test_gap(10);
        test_gap(21);
        test_gap(20);
        test_short_pulse();
        test_shoot_through();
        test_clear();
        test_watchdog();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
